// File: rtl/router_port_drain_pkg.sv
// ----------------------------------------------------------------------------
// router_port_drain_pkg
//   Shared router definitions: header field positions, byte width, the packet
//   parser state encoding and the beat record carried through the drain
//   engine's skid buffer.
//   No ports (package).
// ----------------------------------------------------------------------------
package router_port_drain_pkg;

    localparam int BYTE_W  = 8;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W  = 2;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int STALL_W = 6;

    typedef logic [ADDR_W-1:0] port_addr_t;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } parse_state_e;

    // One byte as presented to the client, together with its framing tags.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              perr;
    } beat_t;

    // Payload length field of a header byte.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] b);
        return b[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_port_drain_if.sv
// ----------------------------------------------------------------------------
// router_port_drain_if
//   Bundles the FIFO-side read/flush signals and the client-side valid/ready
//   byte stream of one router output port.
//   master : the drain engine (reads the FIFO, drives the client)
//   slave  : the environment (FIFO + destination client)
//   Signals:
//     fifo_empty, fifo_data        FIFO status and read data
//     fifo_read_enb                FIFO read strobe
//     fifo_soft_reset              one-cycle FIFO flush pulse
//     out_data/valid/ready         client byte stream handshake
//     out_sop/eop/perr             framing tags and parity error
//     busy                         packet partially drained
// ----------------------------------------------------------------------------
interface router_port_drain_if
    import router_port_drain_pkg::*;
;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_data;
    logic              fifo_read_enb;
    logic              fifo_soft_reset;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sop;
    logic              out_eop;
    logic              out_perr;
    logic              busy;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read_enb, fifo_soft_reset,
        output out_data, out_valid, out_sop, out_eop, out_perr, busy
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read_enb, fifo_soft_reset,
        input  out_data, out_valid, out_sop, out_eop, out_perr, busy
    );

endinterface

// File: rtl/router_skid_buf.sv
// ----------------------------------------------------------------------------
// router_skid_buf
//   Two-entry in-order beat buffer. ent_p0 is always the head.
//   Ports:
//     clock, resetn   clock and asynchronous active-low reset
//     flush           synchronous empty (contents discarded)
//     push, push_beat write one beat
//     pop             remove the head beat
//     head            current head beat (meaningful when occupancy != 0)
//     occupancy       number of stored beats, 0..2
// ----------------------------------------------------------------------------
module router_skid_buf
    import router_port_drain_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] occupancy
);

    logic [1:0] occ;
    beat_t      ent_p0;
    beat_t      ent_p1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage is qualified by occ, so it carries no reset.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (pop) begin
                // Simultaneous push lands behind whatever remains after the pop.
                if (push && occ == 2'd1) begin
                    ent_p0 <= push_beat;
                end else begin
                    ent_p0 <= ent_p1;
                end
                if (push && occ == 2'd2) begin
                    ent_p1 <= push_beat;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    ent_p0 <= push_beat;
                end else begin
                    ent_p1 <= push_beat;
                end
            end
        end
    end

    assign head      = ent_p0;
    assign occupancy = occ;

endmodule

// File: rtl/router_port_drain.sv
// ----------------------------------------------------------------------------
// router_port_drain
//   Read-side engine of one router output port. Pulls bytes from the port
//   FIFO, frames them as header / len payload bytes / parity, and hands them
//   to the client over valid/ready with sop/eop/perr tags. A client that
//   stalls for TIMEOUT consecutive cycles triggers a FIFO soft reset and the
//   partially drained packet is dropped.
//   Parameters:
//     TIMEOUT   consecutive stall cycles before the flush pulse (1..63)
//   Ports:
//     clock     rising-edge clock
//     resetn    asynchronous active-low reset
//     bus       router_port_drain_if.master (FIFO side and client side)
// ----------------------------------------------------------------------------
module router_port_drain
    import router_port_drain_pkg::*;
#(
    parameter int TIMEOUT = 30
) (
    input  logic                       clock,
    input  logic                       resetn,
    router_port_drain_if.master        bus
);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    parse_state_e      state;
    parse_state_e      state_nxt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [LEN_W-1:0]  cnt_inc;
    logic [BYTE_W-1:0] xor_acc;
    logic [BYTE_W-1:0] xor_nxt;
    logic [STALL_W-1:0] stall_cnt;

    logic       inflight;
    logic [1:0] occ;
    logic [1:0] slots_used;
    logic       out_vld;
    logic       pop;
    logic       stall;
    logic       soft_rst;
    logic       rd_en;
    beat_t      cap_beat;
    beat_t      head;

    assign out_vld  = (occ != 2'd0);
    assign pop      = out_vld & bus.out_ready;
    assign stall    = out_vld & ~bus.out_ready;
    assign soft_rst = stall && (stall_cnt == STALL_W'(TIMEOUT - 1));

    // A slot being popped this cycle is free for the byte returning next
    // cycle; counting it keeps the stream at one byte per cycle.
    assign slots_used = occ - {1'b0, pop} + {1'b0, inflight};
    assign rd_en      = resetn & ~bus.fifo_empty & (slots_used < 2'd2) & ~soft_rst;

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        cnt_nxt   = cnt;
        xor_nxt   = xor_acc;
        cnt_inc   = cnt + 1'b1;
        cap_beat  = '{data: bus.fifo_data, sop: 1'b0, eop: 1'b0, perr: 1'b0};
        if (inflight) begin
            case (state)
                HDR: begin
                    cap_beat.sop = 1'b1;
                    len_nxt      = hdr_len(bus.fifo_data);
                    xor_nxt      = bus.fifo_data;
                    state_nxt    = (hdr_len(bus.fifo_data) != '0) ? PAYLOAD : PARITY;
                end
                PAYLOAD: begin
                    xor_nxt = xor_acc ^ bus.fifo_data;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == len) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    cap_beat.eop  = 1'b1;
                    cap_beat.perr = (xor_acc != bus.fifo_data);
                    cnt_nxt       = '0;
                    state_nxt     = HDR;
                end
                default: begin
                    state_nxt = HDR;
                end
            endcase
        end
    end

    // p0 -> p1: read issued, FIFO byte returns next cycle (inflight)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= HDR;
            cnt       <= '0;
            stall_cnt <= '0;
            inflight  <= 1'b0;
        end else if (soft_rst) begin
            state     <= HDR;
            cnt       <= '0;
            stall_cnt <= '0;
            inflight  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            inflight  <= rd_en;
            stall_cnt <= stall ? sat_inc(stall_cnt) : '0;
        end
    end

    // len is reloaded by every header and xor by every header or flush.
    always_ff @(posedge clock) begin
        if (soft_rst) begin
            xor_acc <= '0;
        end else begin
            xor_acc <= xor_nxt;
        end
        len <= len_nxt;
    end

    // p1 -> p2: captured byte enters the skid buffer, head drives the client
    router_skid_buf u_skid_buf (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (soft_rst),
        .push      (inflight),
        .push_beat (cap_beat),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

    assign bus.fifo_read_enb   = rd_en;
    assign bus.fifo_soft_reset = soft_rst;
    assign bus.out_valid       = out_vld;
    assign bus.out_data        = out_vld ? head.data : '0;
    assign bus.out_sop         = out_vld & head.sop;
    assign bus.out_eop         = out_vld & head.eop;
    assign bus.out_perr        = out_vld & head.perr;
    assign bus.busy            = (state != HDR) | out_vld;

endmodule

// File: tb/tb_router_port_drain.sv
// ----------------------------------------------------------------------------
// tb_router_port_drain
//   Scoreboard bench: packet stimulus pushes expected beats into exp_q, a
//   negedge monitor pops and compares every accepted beat. A small FIFO model
//   answers the read strobe with one cycle of latency and honours the flush.
// ----------------------------------------------------------------------------
module tb_router_port_drain;
    import router_port_drain_pkg::*;

    localparam int TIMEOUT = 30;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    router_port_drain_if bus ();

    router_port_drain #(.TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  fifo_q[$];
    logic [7:0]  stage_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  pay[14];

    int cyc        = 0;
    int acc_cnt    = 0;
    int acc_base   = 0;
    int first_cyc  = 0;
    int last_cyc   = 0;
    int ready_mode = 0;
    int out_cnt    = 0;
    int stall_run  = 0;
    bit flush_seen = 1'b0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_beat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clock) cyc++;

    // FIFO model: strobe sampled at an edge, data valid the following cycle.
    always begin : fifo_model
        logic rd_s;
        logic sr_s;
        @(negedge clock);
        rd_s = bus.fifo_read_enb && !bus.fifo_empty;
        sr_s = bus.fifo_soft_reset;
        @(posedge clock);
        #1;
        if (sr_s) begin
            fifo_q.delete();
        end else if (rd_s && fifo_q.size() > 0) begin
            bus.fifo_data = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    // Client ready pattern.
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                case (cyc % 4)
                    0:       bus.out_ready = 1'b1;
                    1:       bus.out_ready = 1'b0;
                    2:       bus.out_ready = 1'b0;
                    default: bus.out_ready = 1'b1;
                endcase
            end
            2:       bus.out_ready = ((acc_cnt - acc_base) < 3);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clock) begin : monitor
        logic v;
        logic r;
        logic [10:0] beat;
        if (!resetn) begin
            prev_stall = 1'b0;
            stall_run  = 0;
            out_cnt    = 0;
        end else begin
            v    = bus.out_valid;
            r    = bus.out_ready;
            beat = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_perr};
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(v), 32'd1);
                chk("stall_beat_hold", 32'(beat), 32'(prev_beat));
            end
            if (bus.fifo_read_enb) begin
                chk("no_read_when_full", 32'((out_cnt - int'(v && r)) <= 1), 32'd1);
            end
            if (v && r) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", beat);
                end else begin
                    chk("beat", 32'(beat), 32'(exp_q.pop_front()));
                end
                if (acc_cnt == acc_base) first_cyc = cyc;
                last_cyc = cyc;
                acc_cnt++;
            end
            if (v && !r) stall_run++;
            else stall_run = 0;
            if (bus.fifo_soft_reset || stall_run == TIMEOUT) begin
                chk("soft_reset_pulse", 32'(bus.fifo_soft_reset), 32'd1);
                chk("soft_reset_stall_cycle", 32'(stall_run), 32'(TIMEOUT));
            end
            out_cnt += int'(bus.fifo_read_enb) - int'(v && r);
            if (bus.fifo_soft_reset) begin
                exp_q.delete();
                out_cnt    = 0;
                stall_run  = 0;
                prev_stall = 1'b0;
                flush_seen = 1'b1;
            end else begin
                prev_stall = v && !r;
                prev_beat  = beat;
            end
        end
    end

    task automatic build_pkt(input logic [7:0] hdr, input int n, input logic [7:0] flip);
        logic [7:0] x;
        logic [7:0] p;
        x = hdr;
        stage_q.push_back(hdr);
        exp_q.push_back({hdr, 3'b100});
        for (int i = 0; i < n; i++) begin
            stage_q.push_back(pay[i]);
            exp_q.push_back({pay[i], 3'b000});
            x = x ^ pay[i];
        end
        p = x ^ flip;
        stage_q.push_back(p);
        exp_q.push_back({p, 2'b01, (flip != 8'h00)});
    endtask

    task automatic fifo_write(input int n);
        for (int i = 0; i < n; i++) begin
            if (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            #2;
            if (exp_q.size() == 0 && !bus.out_valid && fifo_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_sop"}, 32'(bus.out_sop), 32'd0);
        chk({tag, "_eop"}, 32'(bus.out_eop), 32'd0);
        chk({tag, "_perr"}, 32'(bus.out_perr), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_read_enb"}, 32'(bus.fifo_read_enb), 32'd0);
        chk({tag, "_soft_reset"}, 32'(bus.fifo_soft_reset), 32'd0);
    endtask

    initial begin
        bit seen;
        pay[0]  = 8'hA5; pay[1]  = 8'h3C; pay[2]  = 8'h7E; pay[3]  = 8'h01;
        pay[4]  = 8'hFF; pay[5]  = 8'h80; pay[6]  = 8'h5A; pay[7]  = 8'hC3;
        pay[8]  = 8'h12; pay[9]  = 8'h34; pay[10] = 8'h56; pay[11] = 8'h78;
        pay[12] = 8'h9A; pay[13] = 8'hBC;

        resetn = 1'b0;
        @(negedge clock);
        chk_all_zero("reset");
        @(posedge clock);
        #2;
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #2;

        // Clean packet, ready held high.
        ready_mode = 0;
        acc_base   = acc_cnt;
        build_pkt(8'h39, 14, 8'h00);
        fifo_write(16);
        wait_drain("clean_drain");
        chk("clean_beats", 32'(acc_cnt - acc_base), 32'd16);
        chk("clean_back_to_back", 32'(last_cyc - first_cyc), 32'd15);

        // Corrupted parity.
        acc_base = acc_cnt;
        build_pkt(8'h39, 14, 8'h01);
        fifo_write(16);
        wait_drain("badpar_drain");
        chk("badpar_beats", 32'(acc_cnt - acc_base), 32'd16);

        // Zero-length packet.
        acc_base = acc_cnt;
        build_pkt(8'h02, 0, 8'h00);
        fifo_write(2);
        wait_drain("len0_drain");
        chk("len0_beats", 32'(acc_cnt - acc_base), 32'd2);

        // Backpressure, with the FIFO running dry mid-packet.
        ready_mode = 1;
        acc_base   = acc_cnt;
        build_pkt(8'h39, 14, 8'h00);
        fifo_write(8);
        repeat (40) @(posedge clock);
        @(negedge clock);
        chk("busy_mid_packet", 32'(bus.busy), 32'd1);
        chk("valid_idle_mid_packet", 32'(bus.out_valid), 32'd0);
        chk("beats_left_mid_packet", 32'(exp_q.size()), 32'd8);
        @(posedge clock);
        #2;
        fifo_write(8);
        wait_drain("bp_drain");
        chk("bp_beats", 32'(acc_cnt - acc_base), 32'd16);

        // Client stalls from beat 3 onward.
        ready_mode = 2;
        flush_seen = 1'b0;
        acc_base   = acc_cnt;
        build_pkt(8'h39, 14, 8'h00);
        fifo_write(16);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #2;
            if (flush_seen) begin
                seen = 1'b1;
                break;
            end
        end
        chk("timeout_flush_seen", 32'(seen), 32'd1);
        @(negedge clock);
        chk("after_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("after_flush_busy", 32'(bus.busy), 32'd0);
        chk("timeout_beats", 32'(acc_cnt - acc_base), 32'd3);
        @(posedge clock);
        #2;
        ready_mode = 0;
        acc_base   = acc_cnt;
        build_pkt(8'h39, 14, 8'h00);
        fifo_write(16);
        wait_drain("post_flush_drain");
        chk("post_flush_beats", 32'(acc_cnt - acc_base), 32'd16);

        // Reset after payload byte 5.
        acc_base = acc_cnt;
        build_pkt(8'h39, 14, 8'h00);
        fifo_write(16);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #2;
            if (acc_cnt - acc_base >= 6) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reset_point_reached", 32'(seen), 32'd1);
        resetn = 1'b0;
        fifo_q.delete();
        stage_q.delete();
        exp_q.delete();
        @(negedge clock);
        chk_all_zero("midreset");
        @(posedge clock);
        #2;
        resetn = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        acc_base = acc_cnt;
        build_pkt(8'h11, 4, 8'h00);
        fifo_write(6);
        wait_drain("after_reset_drain");
        chk("after_reset_beats", 32'(acc_cnt - acc_base), 32'd6);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_port_drain.md
# router_port_drain

Read-side engine for one router output port. Drains a `router_fifo` instance one byte at a time and re-frames the byte stream into packets: header, then `len` payload bytes, then parity. Delivers the bytes to the destination client over a valid/ready interface with start/end tags and a parity-error flag. Drives the FIFO `soft_reset` when the client stalls past a timeout, so a dead destination cannot block the router.

## Interface
- `TIMEOUT`, 30: consecutive client-stall cycles that trigger a FIFO soft reset (1..63).
- `clock`  in  1  single clock; all logic rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO `data_out`; valid the cycle after a sampled read with `fifo_empty`=0.
- `fifo_read_enb`  out  1  FIFO read strobe.
- `fifo_soft_reset`  out  1  one-cycle flush pulse to the FIFO.
- `out_data`  out  8  byte to client.
- `out_valid`  out  1  `out_data` and tags valid.
- `out_ready`  in  1  client accepts when `out_valid & out_ready`.
- `out_sop`  out  1  current byte is a header.
- `out_eop`  out  1  current byte is parity.
- `out_perr`  out  1  with `out_eop`: computed parity ≠ received parity.
- `busy`  out  1  packet partially drained (state ≠ HDR, or buffer non-empty).

## Operation
- **Buffer.** 2-entry skid buffer; each entry holds {data, sop, eop, perr}.
- **Read issue.** `fifo_read_enb` = !`fifo_empty` & (occupancy + inflight < 2) & !`fifo_soft_reset`.
  - `inflight` is set the cycle after a read is issued.
  - The returned byte is captured into the buffer at that point.
- **Parser.** Classifies each captured byte.
  - Parser states are advanced on capture, not on client accept.
- **HDR state.**
  - Captured byte is tagged sop.
  - `len` ← byte[7:2]; `xor` ← byte.
  - Go to PAYLOAD if `len`≠0, else PARITY.
- **PAYLOAD state.**
  - `xor` ^= byte; `cnt`++.
  - Go to PARITY when `cnt` = `len`.
- **PARITY state.**
  - Captured byte is tagged eop; perr = (`xor` ≠ byte).
  - Return to HDR; clear `cnt`.
- **Output.** Buffer head drives `out_*`; it pops on `out_valid & out_ready`. Order is strictly FIFO.
- **Timeout.**
  - `stall_cnt` increments each cycle with `out_valid & !out_ready`.
  - It clears on any accept, and whenever `out_valid`=0.
  - On `stall_cnt` = `TIMEOUT`−1 with a stall that cycle, assert `fifo_soft_reset` for one cycle.
- **Flush.** On the cycle after `fifo_soft_reset`:
  - Buffer is emptied and the in-flight byte is discarded.
  - Parser returns to HDR; `cnt`, `xor`, `stall_cnt` are cleared.
  - No read is issued during the pulse cycle.
  - The remainder of the dropped packet is not emitted.
- **Arithmetic.** `len`, `cnt` are 6 bits; `xor` is 8 bits; `stall_cnt` is 6 bits and saturates.

## Timing
- **Reset values.** `fifo_read_enb`=0, `fifo_soft_reset`=0, `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `out_perr`=0, `busy`=0. Parser in HDR.
- **Latency.** `fifo_read_enb` sampled at edge N → `out_valid` at edge N+1, if the buffer was empty.
- **Throughput.** With `out_ready` held at 1: 1 byte/cycle sustained.
- **Full buffer.** With the buffer full: no read issued; no byte lost.
- **Empty FIFO.** With `fifo_empty`=1: no read strobe.
  - The parser holds mid-packet indefinitely.
  - Stall does not count unless `out_valid`=1.
- **Simultaneous pop + capture.** Occupancy is unchanged and order is preserved.
- **Ready drop.** `out_valid` never drops without an accept. `out_data` and tags are stable while stalled.
- **Mid-operation reset.** `resetn` low mid-packet clears everything immediately; the first byte after reset is a header.
- **Timeout vs. accept.** A `TIMEOUT`-th stall cycle coinciding with `out_ready`=1 is an accept: no flush.

## Structure
- **Shared router package.**
  - Header field positions: `LEN_MSB`=7, `LEN_LSB`=2, `ADDR_W`=2.
  - Parser state enum {HDR, PAYLOAD, PARITY}.
  - `BYTE_W`=8.
- **Sub-module.** `router_skid_buf`: the 2-entry buffer with push/pop/occupancy. Parser, read issue and timeout stay in the top.

## Test plan
- **Clean packet.** Header 8'h39 (len 14, addr 1), 14 random bytes, correct XOR parity, `out_ready`=1 → 16 beats on consecutive cycles.
  - `out_sop` on beat 0; `out_eop` on beat 15; `out_perr`=0.
- **Bad parity.** Same packet with parity byte XOR 8'h01 → `out_perr`=1 on the eop beat only.
- **len=0.** Header 8'h02 followed by parity 8'h02 → two beats: sop, then eop; `out_perr`=0.
- **Backpressure.**
  - `out_ready` toggles 1,0,0,1 repeatedly → byte sequence is identical to the clean case.
  - No strobe is issued with the buffer full.
  - `out_data` is stable during stalls.
- **Timeout.**
  - `out_ready`=0 from beat 3 onward → `fifo_soft_reset` pulses exactly on the 30th stall cycle.
  - The next cycle has `out_valid`=0 and `busy`=0.
  - The next packet written is emitted from its header.
- **Reset mid-packet.** `resetn` low for 1 cycle after payload byte 5 → all outputs are 0 in the reset cycle. A subsequent header 8'h11 is tagged sop.
